// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with load range check, cascade terminal count and wrap pulse.
// Optional saturating wrap tally enabled by defining COUNT_WRAP_CNT_EN.
module mod_n_counter #(
  parameter int MODULO = 12,
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef COUNT_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_count
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  if (MODULO < 2 || MODULO > 2 ** WIDTH || WRAP_W < 1) begin : g_param_check
    $error("mod_n_counter: illegal MODULO/WIDTH/WRAP_W combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_evt;
  logic             w_load_ok;

  // Explicit compares keep power-of-two MODULO from relying on natural overflow.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cnt,
                                                  input logic up);
    if (up)
      return (cnt == MAX_VAL) ? '0 : cnt + 1'b1;
    else
      return (cnt == '0) ? MAX_VAL : cnt - 1'b1;
  endfunction

  assign w_at_max   = (r_count == MAX_VAL);
  assign w_at_zero  = (r_count == '0);
  assign w_wrap_evt = mode ? w_at_max : w_at_zero;
  assign w_load_ok  = ({1'b0, data_in} < MOD_EXT);

  assign tc       = enable & ~load & ~reset & w_wrap_evt;
  assign data_out = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      if (w_load_ok) begin
        r_count    <= data_in;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
      r_wrap <= 1'b0;
    end else if (enable) begin
      r_count    <= next_count(r_count, mode);
      r_wrap     <= w_wrap_evt;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

`ifdef COUNT_WRAP_CNT_EN
  logic [WRAP_W-1:0] r_wrap_count;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  // Load never clears the tally; only reset does.
  always_ff @(posedge clock) begin
    if (reset)
      r_wrap_count <= '0;
    else if (!load && enable && w_wrap_evt)
      r_wrap_count <= sat_inc(r_wrap_count);
  end

  assign wrap_count = r_wrap_count;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter (MODULO=12, WIDTH=4): directed vector table, random run
// against a modulo-arithmetic reference model, and a wrap tally sequence when enabled.
module tb_mod_n_counter;
  localparam int MODULO = 12;
  localparam int WIDTH  = 4;
  localparam int WRAP_W = 2;

  logic             clock = 1'b0;
  logic             reset, enable, load, mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc, wrap, load_err;
`ifdef COUNT_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_count;
`endif

  mod_n_counter #(.MODULO(MODULO), .WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
`ifdef COUNT_WRAP_CNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, en, ld, md;
    logic [3:0] din;
    logic [3:0] dout;
    logic       wrp, lerr, tcx;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_cnt  = 0;
  int   m_wc   = 0;
  bit   m_wrap = 1'b0;
  bit   m_lerr = 1'b0;
  bit   m_tc   = 1'b0;
  logic cur_tc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, e, l, m, input logic [3:0] d,
                     input logic [3:0] q, input logic w, le, t);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.md = m; v.din = d;
    v.dout = q; v.wrp = w; v.lerr = le; v.tcx = t;
    tbl.push_back(v);
  endtask

  task automatic model_edge(input bit r, e, l, m, input int d);
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_lerr = 0; m_wc = 0;
    end else if (l) begin
      m_wrap = 0;
      m_lerr = (d >= MODULO);
      if (d < MODULO) m_cnt = d;
    end else if (e) begin
      m_wrap = m ? (m_cnt == MODULO - 1) : (m_cnt == 0);
      m_cnt  = m ? (m_cnt + 1) % MODULO : (m_cnt + MODULO - 1) % MODULO;
      m_lerr = 0;
      if (m_wrap && m_wc < (1 << WRAP_W) - 1) m_wc++;
    end else begin
      m_wrap = 0; m_lerr = 0;
    end
  endtask

  task automatic step(input bit r, e, l, m, input int d);
    reset = r; enable = e; load = l; mode = m; data_in = 4'(d);
    #1;
    cur_tc = tc;
    m_tc = e && !l && !r && ((m && m_cnt == MODULO - 1) || (!m && m_cnt == 0));
    @(posedge clock);
    model_edge(r, e, l, m, d);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_tc"},       32'(cur_tc),   32'(m_tc));
    chk({tag, "_data_out"}, 32'(data_out), 32'(m_cnt));
    chk({tag, "_wrap"},     32'(wrap),     32'(m_wrap));
    chk({tag, "_load_err"}, 32'(load_err), 32'(m_lerr));
`ifdef COUNT_WRAP_CNT_EN
    chk({tag, "_wrap_count"}, 32'(wrap_count), 32'(m_wc));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; mode = 1'b0; data_in = '0;

    //  rst en ld md din | dout wrap lerr tc
    add(1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
    add(1, 1, 0, 1, 4'd0,  4'd0, 0, 0, 0);
    for (int k = 0; k < 13; k++)
      add(0, 1, 0, 1, 4'd0, 4'((k + 1) % 12), (k == 11), 0, (k == 11));
    add(0, 1, 1, 1, 4'd7,  4'd7, 0, 0, 0);
    add(0, 1, 0, 1, 4'd0,  4'd8, 0, 0, 0);
    add(0, 1, 1, 1, 4'd12, 4'd8, 0, 1, 0);
    add(0, 0, 0, 1, 4'd0,  4'd8, 0, 0, 0);
    add(0, 0, 1, 0, 4'd15, 4'd8, 0, 1, 0);
    add(0, 0, 0, 0, 4'd0,  4'd8, 0, 0, 0);
    add(0, 0, 1, 0, 4'd5,  4'd5, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 1, 4'd0, 4'd5, 0, 0, 0);
    add(0, 1, 0, 1, 4'd0,  4'd6, 0, 0, 0);
    add(0, 1, 0, 0, 4'd0,  4'd5, 0, 0, 0);
    add(0, 1, 0, 1, 4'd0,  4'd6, 0, 0, 0);
    add(0, 1, 0, 0, 4'd0,  4'd5, 0, 0, 0);
    add(0, 0, 1, 1, 4'd11, 4'd11, 0, 0, 0);
    add(1, 1, 0, 1, 4'd0,  4'd0, 0, 0, 0);
    add(0, 1, 0, 0, 4'd0,  4'd11, 1, 0, 1);
    for (int k = 0; k < 11; k++)
      add(0, 1, 0, 0, 4'd0, 4'(10 - k), 0, 0, 0);
    add(0, 1, 0, 0, 4'd0,  4'd11, 1, 0, 1);
    add(0, 0, 1, 1, 4'd11, 4'd11, 0, 0, 0);
    add(0, 1, 0, 1, 4'd0,  4'd0, 1, 0, 1);
    add(1, 0, 1, 1, 4'd15, 4'd0, 0, 0, 0);
    add(0, 1, 1, 1, 4'd9,  4'd9, 0, 0, 0);
    add(0, 0, 1, 0, 4'd13, 4'd9, 0, 1, 0);
    add(1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].md, int'(tbl[i].din));
      chk($sformatf("vec%0d_tc", i),       32'(cur_tc),   32'(tbl[i].tcx));
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("vec%0d_wrap", i),     32'(wrap),     32'(tbl[i].wrp));
      chk($sformatf("vec%0d_load_err", i), 32'(load_err), 32'(tbl[i].lerr));
`ifdef COUNT_WRAP_CNT_EN
      chk($sformatf("vec%0d_wrap_count", i), 32'(wrap_count), 32'(m_wc));
`endif
    end

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
      chk_model("rand");
    end

`ifdef COUNT_WRAP_CNT_EN
    begin
      int exp_wc[5] = '{1, 2, 3, 3, 3};
      step(1, 0, 0, 0, 0);
      chk("wc_reset", 32'(wrap_count), 32'd0);
      for (int c = 0; c < 5; c++) begin
        for (int k = 0; k < 12; k++) step(0, 1, 0, 1, 0);
        chk($sformatf("wc_cycle%0d", c), 32'(wrap_count), 32'(exp_wc[c]));
        chk($sformatf("wc_cycle%0d_dout", c), 32'(data_out), 32'd0);
      end
      step(0, 1, 1, 1, 4);
      chk("wc_after_load", 32'(wrap_count), 32'd3);
      step(1, 0, 0, 0, 0);
      chk("wc_after_reset", 32'(wrap_count), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
